// File: rtl/alu_reservation_station_if.sv
// Shared widths, control/entry types and the dispatch/CDB/issue bundle of the ALU reservation station.
// The master side feeds dispatch, CDB and alu_ready; the slave side is the station itself.
`ifndef REG_VAL_WIDTH
`define REG_VAL_WIDTH 32
`endif
`ifndef PHYSICAL_REG_NUM_WIDTH
`define PHYSICAL_REG_NUM_WIDTH 6
`endif
`ifndef INST_ADDR_WIDTH
`define INST_ADDR_WIDTH 32
`endif
`ifndef ROB_SIZE_WIDTH
`define ROB_SIZE_WIDTH 5
`endif

package alu_rs_pkg;
    localparam int REG_W  = `REG_VAL_WIDTH;
    localparam int PREG_W = `PHYSICAL_REG_NUM_WIDTH;
    localparam int ADDR_W = `INST_ADDR_WIDTH;
    localparam int ROB_W  = `ROB_SIZE_WIDTH;

    typedef struct packed {
        logic [3:0] alu_op;
        logic       use_imm;
        logic       is_branch;
    } control_t;

    typedef struct packed {
        logic              s1_rdy;
        logic [PREG_W-1:0] s1_tag;
        logic [REG_W-1:0]  s1_val;
        logic              s2_rdy;
        logic [PREG_W-1:0] s2_tag;
        logic [REG_W-1:0]  s2_val;
        logic [PREG_W-1:0] dst;
        control_t          ctrl;
        logic [REG_W-1:0]  imm;
        logic [ADDR_W-1:0] pc;
        logic [ROB_W-1:0]  rob;
    } entry_t;
endpackage

interface alu_reservation_station_if;
    import alu_rs_pkg::*;

    logic              disp_valid;
    logic              disp_ready;
    logic [PREG_W-1:0] disp_src1_tag;
    logic [PREG_W-1:0] disp_src2_tag;
    logic              disp_src1_rdy;
    logic              disp_src2_rdy;
    logic [REG_W-1:0]  disp_src1_val;
    logic [REG_W-1:0]  disp_src2_val;
    logic [PREG_W-1:0] disp_dst_addr;
    control_t          disp_control;
    logic [REG_W-1:0]  disp_imm;
    logic [ADDR_W-1:0] disp_pc;
    logic [ROB_W-1:0]  disp_rob_tag;

    logic              cdb_valid;
    logic [PREG_W-1:0] cdb_addr;
    logic [REG_W-1:0]  cdb_val;

    logic              alu_ready;
    logic              rs_valid;
    logic [REG_W-1:0]  src_reg1_val;
    logic [REG_W-1:0]  src_reg2_val;
    logic [PREG_W-1:0] dst_reg_addr;
    control_t          control;
    logic [REG_W-1:0]  immediate;
    logic [ADDR_W-1:0] pc_in;
    logic [ROB_W-1:0]  new_inst_tag_in;

    modport master (
        output disp_valid, disp_src1_tag, disp_src2_tag, disp_src1_rdy, disp_src2_rdy,
               disp_src1_val, disp_src2_val, disp_dst_addr, disp_control, disp_imm,
               disp_pc, disp_rob_tag, cdb_valid, cdb_addr, cdb_val, alu_ready,
        input  disp_ready, rs_valid, src_reg1_val, src_reg2_val, dst_reg_addr, control,
               immediate, pc_in, new_inst_tag_in
    );

    modport slave (
        input  disp_valid, disp_src1_tag, disp_src2_tag, disp_src1_rdy, disp_src2_rdy,
               disp_src1_val, disp_src2_val, disp_dst_addr, disp_control, disp_imm,
               disp_pc, disp_rob_tag, cdb_valid, cdb_addr, cdb_val, alu_ready,
        output disp_ready, rs_valid, src_reg1_val, src_reg2_val, dst_reg_addr, control,
               immediate, pc_in, new_inst_tag_in
    );
endinterface

// File: rtl/alu_reservation_station.sv
// Collapsing-queue reservation station in front of the ALU: entry 0 is the oldest, operands are
// captured at dispatch or snooped off the CDB, and the oldest entry with both operands ready issues.
module alu_reservation_station
    import alu_rs_pkg::*;
#(
    parameter int NUM_ENTRIES = 4,
    parameter int CNT_WIDTH   = $clog2(NUM_ENTRIES + 1)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     flush,
    alu_reservation_station_if.slave rs_if
);
    localparam int IDX_W = $clog2(NUM_ENTRIES);

    entry_t                 r_entry [NUM_ENTRIES];
    entry_t                 w_wake  [NUM_ENTRIES];
    entry_t                 w_next  [NUM_ENTRIES];
    logic [NUM_ENTRIES-1:0] w_ready;
    logic [CNT_WIDTH-1:0]   r_count;
    logic [CNT_WIDTH-1:0]   w_wr_idx;
    logic [IDX_W-1:0]       w_sel;
    logic                   w_any;
    logic                   w_issue;
    logic                   w_disp;
    logic                   w_disp_ready;
    entry_t                 w_disp_raw;
    entry_t                 w_disp_entry;

    logic                   r_rs_valid;
    logic [REG_W-1:0]       r_src_reg1_val;
    logic [REG_W-1:0]       r_src_reg2_val;
    logic [PREG_W-1:0]      r_dst_reg_addr;
    control_t               r_control;
    logic [REG_W-1:0]       r_immediate;
    logic [ADDR_W-1:0]      r_pc_in;
    logic [ROB_W-1:0]       r_new_inst_tag_in;

    // CDB tag match on a not-yet-ready operand captures the broadcast value.
    function automatic entry_t f_wake(input entry_t e, input logic v,
                                      input logic [PREG_W-1:0] a, input logic [REG_W-1:0] d);
        entry_t o;
        o = e;
        if (v && !e.s1_rdy && (e.s1_tag == a)) begin
            o.s1_rdy = 1'b1;
            o.s1_val = d;
        end
        if (v && !e.s2_rdy && (e.s2_tag == a)) begin
            o.s2_rdy = 1'b1;
            o.s2_val = d;
        end
        return o;
    endfunction

    assign w_disp_ready = (r_count < CNT_WIDTH'(NUM_ENTRIES));
    assign w_disp       = rs_if.disp_valid && w_disp_ready && !flush;
    assign w_issue      = rs_if.alu_ready && !r_rs_valid && w_any && !flush;
    assign w_wr_idx     = r_count - CNT_WIDTH'(w_issue);

    assign w_disp_raw = '{
        s1_rdy: rs_if.disp_src1_rdy, s1_tag: rs_if.disp_src1_tag, s1_val: rs_if.disp_src1_val,
        s2_rdy: rs_if.disp_src2_rdy, s2_tag: rs_if.disp_src2_tag, s2_val: rs_if.disp_src2_val,
        dst: rs_if.disp_dst_addr, ctrl: rs_if.disp_control, imm: rs_if.disp_imm,
        pc: rs_if.disp_pc, rob: rs_if.disp_rob_tag
    };
    assign w_disp_entry = f_wake(w_disp_raw, rs_if.cdb_valid, rs_if.cdb_addr, rs_if.cdb_val);

    // Eligibility uses registered ready bits only, so a wakeup counts from the next cycle.
    always_comb begin
        w_sel = '0;
        w_any = 1'b0;
        for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
            if (w_ready[i]) begin
                w_sel = IDX_W'(i);
                w_any = 1'b1;
            end
        end
    end

    for (genvar gi = 0; gi < NUM_ENTRIES; gi++) begin : g_entry
        entry_t w_up;
        logic   w_shift;
        logic   w_take;

        assign w_wake[gi]  = f_wake(r_entry[gi], rs_if.cdb_valid, rs_if.cdb_addr, rs_if.cdb_val);
        assign w_ready[gi] = (r_count > CNT_WIDTH'(gi)) && r_entry[gi].s1_rdy && r_entry[gi].s2_rdy;

        if (gi < NUM_ENTRIES - 1) begin : g_up
            assign w_up = w_wake[gi + 1];
        end else begin : g_top
            assign w_up = w_wake[gi];
        end

        // Slots at or above the issued one collapse down; the dispatch lands at the new tail.
        assign w_shift    = w_issue && (IDX_W'(gi) >= w_sel);
        assign w_take     = w_disp && (w_wr_idx == CNT_WIDTH'(gi));
        assign w_next[gi] = w_take ? w_disp_entry : (w_shift ? w_up : w_wake[gi]);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                r_entry[i] <= '0;
            end
            r_count    <= '0;
            r_rs_valid <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                r_entry[i] <= w_next[i];
            end
            if (flush) begin
                r_count    <= '0;
                r_rs_valid <= 1'b0;
            end else begin
                r_count    <= r_count - CNT_WIDTH'(w_issue) + CNT_WIDTH'(w_disp);
                r_rs_valid <= w_issue;
            end
        end
    end

    // Payload is a snapshot taken at issue and held until the next issue.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_src_reg1_val    <= '0;
            r_src_reg2_val    <= '0;
            r_dst_reg_addr    <= '0;
            r_control         <= '0;
            r_immediate       <= '0;
            r_pc_in           <= '0;
            r_new_inst_tag_in <= '0;
        end else if (w_issue) begin
            r_src_reg1_val    <= r_entry[w_sel].s1_val;
            r_src_reg2_val    <= r_entry[w_sel].s2_val;
            r_dst_reg_addr    <= r_entry[w_sel].dst;
            r_control         <= r_entry[w_sel].ctrl;
            r_immediate       <= r_entry[w_sel].imm;
            r_pc_in           <= r_entry[w_sel].pc;
            r_new_inst_tag_in <= r_entry[w_sel].rob;
        end
    end

    assign rs_if.disp_ready      = w_disp_ready;
    assign rs_if.rs_valid        = r_rs_valid;
    assign rs_if.src_reg1_val    = r_src_reg1_val;
    assign rs_if.src_reg2_val    = r_src_reg2_val;
    assign rs_if.dst_reg_addr    = r_dst_reg_addr;
    assign rs_if.control         = r_control;
    assign rs_if.immediate       = r_immediate;
    assign rs_if.pc_in           = r_pc_in;
    assign rs_if.new_inst_tag_in = r_new_inst_tag_in;

endmodule

// File: tb/tb_alu_reservation_station.sv
// Randomized and directed bench for alu_reservation_station against a queue-based reference model.
module tb_alu_reservation_station;
    import alu_rs_pkg::*;

    localparam int N      = 4;
    localparam int CTRL_W = $bits(control_t);

    logic clk = 1'b0;
    logic reset;
    logic flush;
    int   n_total = 0;
    int   n_bad   = 0;

    alu_reservation_station_if rs_if ();

    alu_reservation_station #(.NUM_ENTRIES(N)) dut (
        .clk   (clk),
        .reset (reset),
        .flush (flush),
        .rs_if (rs_if)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit                s1_rdy;
        logic [PREG_W-1:0] s1_tag;
        logic [REG_W-1:0]  s1_val;
        bit                s2_rdy;
        logic [PREG_W-1:0] s2_tag;
        logic [REG_W-1:0]  s2_val;
        logic [PREG_W-1:0] dst;
        control_t          ctrl;
        logic [REG_W-1:0]  imm;
        logic [ADDR_W-1:0] pc;
        logic [ROB_W-1:0]  rob;
    } m_ent_t;

    m_ent_t m_q[$];
    m_ent_t m_out;
    bit     m_rs_valid;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic model_clear();
        m_q.delete();
        m_rs_valid = 1'b0;
        m_out      = '{default: '0};
    endtask

    task automatic check_outputs();
        check_val("rs_valid", 64'(rs_if.rs_valid), 64'(m_rs_valid));
        check_val("src1_val", 64'(rs_if.src_reg1_val), 64'(m_out.s1_val));
        check_val("src2_val", 64'(rs_if.src_reg2_val), 64'(m_out.s2_val));
        check_val("dst", 64'(rs_if.dst_reg_addr), 64'(m_out.dst));
        check_val("control", 64'({rs_if.control}), 64'({m_out.ctrl}));
        check_val("imm", 64'(rs_if.immediate), 64'(m_out.imm));
        check_val("pc", 64'(rs_if.pc_in), 64'(m_out.pc));
        check_val("rob", 64'(rs_if.new_inst_tag_in), 64'(m_out.rob));
    endtask

    // One clock: predict from current inputs, clock the DUT, compare.
    task automatic step();
        m_ent_t e;
        int     idx;
        bit     room;
        room = (m_q.size() < N);
        check_val("disp_ready", 64'(rs_if.disp_ready), 64'(room));
        if (flush) begin
            m_q.delete();
            m_rs_valid = 1'b0;
        end else begin
            idx = -1;
            if (rs_if.alu_ready && !m_rs_valid)
                foreach (m_q[i])
                    if (idx < 0 && m_q[i].s1_rdy && m_q[i].s2_rdy) idx = i;
            m_rs_valid = (idx >= 0);
            if (idx >= 0) begin
                m_out = m_q[idx];
                m_q.delete(idx);
            end
            for (int i = 0; i < m_q.size(); i++) begin
                e = m_q[i];
                if (rs_if.cdb_valid && !e.s1_rdy && e.s1_tag == rs_if.cdb_addr) begin
                    e.s1_rdy = 1'b1;
                    e.s1_val = rs_if.cdb_val;
                end
                if (rs_if.cdb_valid && !e.s2_rdy && e.s2_tag == rs_if.cdb_addr) begin
                    e.s2_rdy = 1'b1;
                    e.s2_val = rs_if.cdb_val;
                end
                m_q[i] = e;
            end
            if (rs_if.disp_valid && room) begin
                e.s1_rdy = rs_if.disp_src1_rdy;  e.s1_tag = rs_if.disp_src1_tag;
                e.s1_val = rs_if.disp_src1_val;
                e.s2_rdy = rs_if.disp_src2_rdy;  e.s2_tag = rs_if.disp_src2_tag;
                e.s2_val = rs_if.disp_src2_val;
                e.dst = rs_if.disp_dst_addr;     e.ctrl = rs_if.disp_control;
                e.imm = rs_if.disp_imm;          e.pc = rs_if.disp_pc;
                e.rob = rs_if.disp_rob_tag;
                if (rs_if.cdb_valid && !e.s1_rdy && e.s1_tag == rs_if.cdb_addr) begin
                    e.s1_rdy = 1'b1;
                    e.s1_val = rs_if.cdb_val;
                end
                if (rs_if.cdb_valid && !e.s2_rdy && e.s2_tag == rs_if.cdb_addr) begin
                    e.s2_rdy = 1'b1;
                    e.s2_val = rs_if.cdb_val;
                end
                m_q.push_back(e);
            end
        end
        @(posedge clk);
        #1;
        check_outputs();
        if (m_rs_valid)
            $display("issue dst=%0d rob=%0d src1=%0h src2=%0h", m_out.dst, m_out.rob,
                     m_out.s1_val, m_out.s2_val);
    endtask

    task automatic idle();
        rs_if.disp_valid = 1'b0;
        rs_if.cdb_valid  = 1'b0;
        flush            = 1'b0;
    endtask

    task automatic set_disp(input int t1, input bit r1, input int v1,
                            input int t2, input bit r2, input int v2, input int dst);
        rs_if.disp_valid    = 1'b1;
        rs_if.disp_src1_tag = PREG_W'(t1);
        rs_if.disp_src1_rdy = r1;
        rs_if.disp_src1_val = REG_W'(v1);
        rs_if.disp_src2_tag = PREG_W'(t2);
        rs_if.disp_src2_rdy = r2;
        rs_if.disp_src2_val = REG_W'(v2);
        rs_if.disp_dst_addr = PREG_W'(dst);
        rs_if.disp_control  = control_t'(CTRL_W'($urandom));
        rs_if.disp_imm      = REG_W'($urandom);
        rs_if.disp_pc       = ADDR_W'($urandom);
        rs_if.disp_rob_tag  = ROB_W'($urandom);
    endtask

    task automatic set_cdb(input int tag, input int val);
        rs_if.cdb_valid = 1'b1;
        rs_if.cdb_addr  = PREG_W'(tag);
        rs_if.cdb_val   = REG_W'(val);
    endtask

    initial begin
        reset = 1'b1;
        idle();
        set_disp(0, 0, 0, 0, 0, 0, 0);
        rs_if.disp_valid = 1'b0;
        rs_if.cdb_addr   = '0;
        rs_if.cdb_val    = '0;
        rs_if.alu_ready  = 1'b0;
        model_clear();
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        check_val("reset_disp_ready", 64'(rs_if.disp_ready), 64'd1);
        check_outputs();

        // Both operands ready at dispatch.
        rs_if.alu_ready = 1'b1;
        set_disp(1, 1, 3, 2, 1, 4, 5);
        step(); idle(); step(); step();

        // src1 woken by a later broadcast.
        set_disp(7, 0, 0, 2, 1, 9, 6);
        step(); idle(); set_cdb(7, 'h10);
        step(); idle(); step(); step();

        // Broadcast in the dispatch cycle itself.
        set_disp(7, 0, 0, 2, 1, 1, 8); set_cdb(7, 'h22);
        step(); idle(); step(); step();

        // Fill with waiting entries; a fifth, fully ready dispatch must be dropped.
        rs_if.alu_ready = 1'b0;
        for (int k = 0; k < N; k++) begin
            set_disp(10 + k, 0, 0, 40, 1, k, 20 + k);
            step();
        end
        set_disp(30, 1, 'h99, 31, 1, 'h98, 29);
        step(); idle();
        rs_if.alu_ready = 1'b1; set_cdb(12, 'h77);
        step(); idle(); step(); step();

        // Flush with three entries and a dispatch pending.
        set_disp(33, 1, 1, 34, 1, 2, 35); flush = 1'b1;
        step(); idle(); step(); step();

        // Two entries woken together issue oldest first, not back to back.
        rs_if.alu_ready = 1'b0;
        set_disp(20, 0, 0, 21, 1, 5, 1); step();
        set_disp(20, 0, 0, 22, 1, 6, 2); step();
        idle(); set_cdb(20, 'h55); step();
        idle(); rs_if.alu_ready = 1'b1;
        repeat (4) step();

        // Random traffic with a small tag space so CDB hits are frequent.
        for (int cyc = 0; cyc < 600; cyc++) begin
            if (cyc == 300) begin
                #2 reset = 1'b1;
                #1;
                model_clear();
                check_val("async_reset_disp_ready", 64'(rs_if.disp_ready), 64'd1);
                check_outputs();
                @(posedge clk);
                #1 reset = 1'b0;
            end
            set_disp($urandom_range(0, 7), $urandom_range(0, 1) == 1, $urandom,
                     $urandom_range(0, 7), $urandom_range(0, 1) == 1, $urandom,
                     $urandom_range(0, 63));
            rs_if.disp_valid = ($urandom_range(0, 9) < 6);
            rs_if.cdb_valid  = ($urandom_range(0, 1) == 1);
            rs_if.cdb_addr   = PREG_W'($urandom_range(0, 7));
            rs_if.cdb_val    = REG_W'($urandom);
            rs_if.alu_ready  = ($urandom_range(0, 9) < 7);
            flush            = ($urandom_range(0, 49) == 0);
            step();
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
